// File: rtl/seg_scan_display.sv
// Multiplexed common-cathode 7-segment scan driver with frame snapshot,
// leading-zero blanking, per-digit dp/blink and inter-digit CS blanking.
module seg_scan_display #(
    parameter int unsigned DIGITS       = 6,
    parameter int unsigned SCAN_DIV     = 200,
    parameter int unsigned BLANK_CYC    = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [1:0]            Sel,
    input  logic [4*DIGITS-1:0]   Value_A,
    input  logic [4*DIGITS-1:0]   Value_B,
    input  logic [4*DIGITS-1:0]   Value_C,
    input  logic [DIGITS-1:0]     Dp_Mask,
    input  logic [DIGITS-1:0]     Blink_Mask,
    input  logic                  Lz_En,
    output logic [7:0]            Digitron_Out,
    output logic [DIGITS-1:0]     DigitronCS_Out,
    output logic                  Frame_Start
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    typedef enum logic {ST_WAIT, ST_SCAN} state_t;
    state_t state_q, state_d;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tick, frame_tick, in_blank;
    logic [1:0]        snap_sel;
    logic [VW-1:0]     snap_val, live_val, cur_val;
    logic [DIGITS-1:0] snap_dp, snap_blink, cur_dp, cur_blink;
    logic              snap_lz, cur_lz;
    logic [1:0]        cur_sel;
    logic [FW-1:0]     fcnt_q;
    logic              phase_q, phase_d, frame_done;
    logic [3:0]        nib;
    logic              dp_bit, blink_bit, upper_nz, lz_blank;
    logic [7:0]        seg_d;
    logic [DIGITS-1:0] cs_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        tick       = (presc_q == PW'(SCAN_DIV - 1));
        frame_tick = tick && (idx_q == IW'(DIGITS - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        if (!tick)           idx_d = idx_q;
        else if (frame_tick) idx_d = '0;
        else                 idx_d = idx_q + 1'b1;
    end

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (presc_d < PW'(BLANK_CYC));
        end
    endgenerate

    always_comb begin
        case (Sel)
            2'd0:    live_val = Value_A;
            2'd1:    live_val = Value_B;
            2'd2:    live_val = Value_C;
            default: live_val = '0;
        endcase
    end

    // Digit 0 is loaded on the same edge as the snapshot, so it reads the live inputs.
    always_comb begin
        cur_sel   = frame_tick ? Sel        : snap_sel;
        cur_val   = frame_tick ? live_val   : snap_val;
        cur_dp    = frame_tick ? Dp_Mask    : snap_dp;
        cur_blink = frame_tick ? Blink_Mask : snap_blink;
        cur_lz    = frame_tick ? Lz_En      : snap_lz;
    end

    // The first frame after reset is not a completed frame, hence the ST_SCAN qualifier.
    always_comb begin
        frame_done = frame_tick && (state_q == ST_SCAN);
        phase_d    = phase_q;
        if (frame_done && (fcnt_q == FW'(BLINK_FRAMES - 1)))
            phase_d = ~phase_q;
    end

    always_comb begin
        nib       = '0;
        dp_bit    = 1'b0;
        blink_bit = 1'b0;
        upper_nz  = 1'b0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_d) begin
                nib       = cur_val[4*j +: 4];
                dp_bit    = cur_dp[j];
                blink_bit = cur_blink[j];
            end
            if ((IW'(j) >= idx_d) && (cur_val[4*j +: 4] != 4'h0))
                upper_nz = 1'b1;
        end
        lz_blank = cur_lz && (cur_sel != 2'd3) && (idx_d != '0) && !upper_nz;
        if (cur_sel == 2'd3) seg_d = 8'h40;
        else if (lz_blank)   seg_d = 8'h00;
        else                 seg_d = {1'b0, hex7(nib)};
        seg_d[7] = dp_bit;
        if (phase_d && blink_bit)
            seg_d = '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= ST_WAIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) state_d = ST_SCAN;
    end

    always_comb begin
        cs_d = '1;
        if (((state_q == ST_SCAN) || tick) && !in_blank)
            cs_d = ~(DIGITS'(1) << idx_d);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q        <= '0;
            idx_q          <= IW'(DIGITS - 1);
            Digitron_Out   <= '0;
            DigitronCS_Out <= '1;
            Frame_Start    <= 1'b0;
            phase_q        <= 1'b0;
            fcnt_q         <= '0;
            snap_sel       <= '0;
            snap_val       <= '0;
            snap_dp        <= '0;
            snap_blink     <= '0;
            snap_lz        <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            DigitronCS_Out <= cs_d;
            Frame_Start    <= frame_tick;
            phase_q        <= phase_d;
            if (tick)
                Digitron_Out <= seg_d;
            if (frame_done)
                fcnt_q <= (fcnt_q == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt_q + 1'b1;
            if (frame_tick) begin
                snap_sel   <= Sel;
                snap_val   <= live_val;
                snap_dp    <= Dp_Mask;
                snap_blink <= Blink_Mask;
                snap_lz    <= Lz_En;
            end
        end
    end

endmodule
